// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and baud encodings, the reset configuration
// and the receive-controller FSM state encoding.
package uart_pkg;

    localparam logic [1:0] PARITY_EVEN = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_NONE = 2'b10;   // any 1x code disables parity

    localparam logic [1:0] BAUD_9600   = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    typedef struct packed {
        logic [1:0] baud;
        logic [1:0] parity;
        logic       stop;
    } uart_cfg_t;

    localparam uart_cfg_t CFG_RESET = '{baud: BAUD_9600, parity: PARITY_NONE, stop: 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_APPLY = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head entry is presented combinationally while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == 5'd0);
    assign full    = (count_reg == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When full, wr_ptr equals rd_ptr: the old head is read before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 5'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: tracks frames on the raw line, applies configuration
// only between frames, and buffers received bytes with their error flag.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx,
    input  logic [1:0] CfgBaud,
    input  logic [1:0] CfgParity,
    input  logic       CfgStop,
    input  logic       CfgWr,
    output logic       CfgAck,
    output logic [1:0] BaudRate,
    output logic [1:0] ParityMode,
    output logic       StopBits,
    input  logic [7:0] RxData,
    input  logic       RxDataReady,
    input  logic       Error,
    output logic [7:0] DataOut,
    output logic       DataErr,
    output logic       DataValid,
    input  logic       DataReady,
    output logic [4:0] Count,
    output logic       Overrun,
    input  logic       OverrunClr,
    output logic [7:0] ErrCount,
    output logic       Busy
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    rx_state_t   state_reg;
    rx_state_t   state_next;
    logic        rx_sync1_reg;
    logic        rx_sync2_reg;
    logic        rx_prev_reg;
    logic        rdy_prev_reg;
    logic        push_reg;
    logic [8:0]  push_data_reg;
    logic [TW-1:0] timer_reg;
    logic        pend_valid_reg;
    uart_cfg_t   pend_cfg_reg;
    uart_cfg_t   cfg_reg;
    logic        overrun_reg;
    logic [7:0]  err_count_reg;

    logic        frame_start;
    logic        rdy_rise;
    logic        timeout;
    logic        apply_en;
    logic        cfg_ack;
    logic        busy;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_head;

    assign frame_start = rx_prev_reg && !rx_sync2_reg && (state_reg == ST_IDLE);
    assign rdy_rise    = RxDataReady && !rdy_prev_reg;
    assign timeout     = (timer_reg == TW'(FRAME_TIMEOUT - 1));
    assign apply_en    = (state_reg == ST_IDLE) && (state_next == ST_APPLY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rdy_prev_reg <= 1'b0;
        end else begin
            rx_sync1_reg <= Rx;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
            rdy_prev_reg <= RxDataReady;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A frame start takes priority over applying pending configuration.
    always_comb begin
        state_next = state_reg;
        cfg_ack    = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_FRAME;
                end else if (pend_valid_reg) begin
                    state_next = ST_APPLY;
                end
            end
            ST_FRAME: begin
                busy = 1'b1;
                if (rdy_rise || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            ST_APPLY: begin
                cfg_ack    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timer is held at zero outside FRAME, so every frame starts a fresh count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_reg <= '0;
        end else if (state_reg != ST_FRAME) begin
            timer_reg <= '0;
        end else if (!timeout) begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    // Config is loaded on APPLY entry so the new values and CfgAck share a cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_valid_reg <= 1'b0;
            pend_cfg_reg   <= CFG_RESET;
            cfg_reg        <= CFG_RESET;
        end else begin
            if (apply_en) begin
                cfg_reg        <= pend_cfg_reg;
                pend_valid_reg <= 1'b0;
            end
            if (CfgWr) begin
                pend_valid_reg <= 1'b1;
                pend_cfg_reg   <= '{baud: CfgBaud, parity: CfgParity, stop: CfgStop};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            push_reg      <= 1'b0;
            push_data_reg <= 9'd0;
        end else begin
            push_reg <= rdy_rise;
            if (rdy_rise) begin
                push_data_reg <= {Error, RxData};
            end
        end
    end

    assign pop = !fifo_empty && DataReady;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun_reg   <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            if (push_reg && fifo_full && !pop) begin
                overrun_reg <= 1'b1;
            end else if (OverrunClr) begin
                overrun_reg <= 1'b0;
            end
            if (push_reg && push_data_reg[8] && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_reg),
        .push_data (push_data_reg),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (Count)
    );

    assign DataOut    = fifo_head[7:0];
    assign DataErr    = fifo_head[8];
    assign DataValid  = !fifo_empty;
    assign CfgAck     = cfg_ack;
    assign Busy       = busy;
    assign BaudRate   = cfg_reg.baud;
    assign ParityMode = cfg_reg.parity;
    assign StopBits   = cfg_reg.stop;
    assign Overrun    = overrun_reg;
    assign ErrCount   = err_count_reg;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: a queue holds the bytes expected
// to be stored, and every pop is compared against its front.
module tb_uart_rx_controller;

    localparam int DEPTH         = 8;
    localparam int FRAME_TIMEOUT = 100;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Rx = 1'b1;
    logic [1:0] CfgBaud = 2'b00;
    logic [1:0] CfgParity = 2'b00;
    logic       CfgStop = 1'b0;
    logic       CfgWr = 1'b0;
    logic       CfgAck;
    logic [1:0] BaudRate;
    logic [1:0] ParityMode;
    logic       StopBits;
    logic [7:0] RxData = 8'h00;
    logic       RxDataReady = 1'b0;
    logic       Error = 1'b0;
    logic [7:0] DataOut;
    logic       DataErr;
    logic       DataValid;
    logic       DataReady = 1'b0;
    logic [4:0] Count;
    logic       Overrun;
    logic       OverrunClr = 1'b0;
    logic [7:0] ErrCount;
    logic       Busy;

    always #5 CLK = ~CLK;

    uart_rx_controller #(
        .DEPTH         (DEPTH),
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Rx          (Rx),
        .CfgBaud     (CfgBaud),
        .CfgParity   (CfgParity),
        .CfgStop     (CfgStop),
        .CfgWr       (CfgWr),
        .CfgAck      (CfgAck),
        .BaudRate    (BaudRate),
        .ParityMode  (ParityMode),
        .StopBits    (StopBits),
        .RxData      (RxData),
        .RxDataReady (RxDataReady),
        .Error       (Error),
        .DataOut     (DataOut),
        .DataErr     (DataErr),
        .DataValid   (DataValid),
        .DataReady   (DataReady),
        .Count       (Count),
        .Overrun     (Overrun),
        .OverrunClr  (OverrunClr),
        .ErrCount    (ErrCount),
        .Busy        (Busy)
    );

    int         checks = 0;
    int         failures = 0;
    int         err_model = 0;
    int         ack_total = 0;
    logic [8:0] sb_q[$];

    always @(negedge CLK) begin
        if (CfgAck === 1'b1) begin
            ack_total++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame();
        int n;
        n = 0;
        Rx = 1'b0;
        while (!Busy && n < 10) begin
            tick();
            n++;
        end
        check_val("frame_start_busy", 32'(Busy), 32'd1);
        Rx = 1'b1;
    endtask

    // mode 0: plain push; 1: pop in the push cycle; 2: OverrunClr in the push cycle
    task automatic end_frame(input logic [7:0] d, input logic e, input int mode);
        logic [8:0] head;
        RxData      = d;
        Error       = e;
        RxDataReady = 1'b1;
        tick();
        if (mode == 1) begin
            head = 9'h1FF;
            if (sb_q.size() > 0) begin
                head = sb_q.pop_front();
            end
            check_val("simul_pop_valid", 32'(DataValid), 32'd1);
            check_val("simul_pop_data", 32'({DataErr, DataOut}), 32'(head));
            DataReady = 1'b1;
            sb_q.push_back({e, d});
        end else begin
            if (mode == 2) begin
                OverrunClr = 1'b1;
            end
            if (sb_q.size() < DEPTH) begin
                sb_q.push_back({e, d});
            end
        end
        if (e && err_model < 255) begin
            err_model++;
        end
        $display("frame data=0x%02h err=%0b mode=%0d", d, e, mode);
        tick();
        DataReady  = 1'b0;
        OverrunClr = 1'b0;
        tick();
        RxDataReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_frame(input logic [7:0] d, input logic e, input int mode);
        start_frame();
        end_frame(d, e, mode);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        exp = 9'h1FF;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
        end
        check_val({tag, "_valid"}, 32'(DataValid), 32'd1);
        check_val({tag, "_data"}, 32'({DataErr, DataOut}), 32'(exp));
        $display("pop %s data=0x%02h err=%0b", tag, DataOut, DataErr);
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
    endtask

    initial begin
        int ack_n;
        int a0;
        int busy_n;
        int found;

        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_count", 32'(Count), 32'd0);
        check_val("rst_valid", 32'(DataValid), 32'd0);
        check_val("rst_dataout", 32'({DataErr, DataOut}), 32'd0);
        check_val("rst_overrun", 32'(Overrun), 32'd0);
        check_val("rst_errcount", 32'(ErrCount), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_cfgack", 32'(CfgAck), 32'd0);
        check_val("rst_cfg", 32'({BaudRate, ParityMode, StopBits}), 32'b00_10_0);
        RST = 1'b0;
        tick();

        // configuration write while idle
        CfgBaud = 2'b10; CfgParity = 2'b01; CfgStop = 1'b1; CfgWr = 1'b1;
        ack_n = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) CfgWr = 1'b0;
            if (CfgAck) begin
                ack_n = n;
                break;
            end
        end
        check_val("idle_ack_latency", 32'(ack_n), 32'd2);
        check_val("idle_cfg", 32'({BaudRate, ParityMode, StopBits}), 32'b10_01_1);
        tick();
        check_val("idle_ack_pulse", 32'(CfgAck), 32'd0);

        // configuration write during a frame
        start_frame();
        a0 = ack_total;
        CfgBaud = 2'b11; CfgParity = 2'b00; CfgStop = 1'b0; CfgWr = 1'b1;
        tick();
        CfgWr = 1'b0;
        repeat (5) tick();
        check_val("frame_cfg_hold", 32'({BaudRate, ParityMode, StopBits}), 32'b10_01_1);
        check_val("frame_no_ack", 32'(ack_total - a0), 32'd0);
        check_val("frame_busy", 32'(Busy), 32'd1);
        end_frame(8'h5A, 1'b0, 0);
        repeat (4) tick();
        check_val("frame_ack_once", 32'(ack_total - a0), 32'd1);
        check_val("frame_cfg_new", 32'({BaudRate, ParityMode, StopBits}), 32'b11_00_0);
        pop_check("midframe");

        // fill past full, overrun behaviour, push+pop when full
        for (int i = 1; i <= 9; i++) begin
            do_frame(8'(i), 1'b0, 0);
        end
        check_val("full_count", 32'(Count), 32'd8);
        check_val("full_overrun", 32'(Overrun), 32'd1);
        do_frame(8'h0B, 1'b0, 2);
        check_val("clr_vs_set_overrun", 32'(Overrun), 32'd1);
        check_val("clr_vs_set_count", 32'(Count), 32'd8);
        OverrunClr = 1'b1;
        tick();
        OverrunClr = 1'b0;
        check_val("overrun_clr", 32'(Overrun), 32'd0);
        do_frame(8'hAA, 1'b0, 1);
        check_val("simul_count", 32'(Count), 32'd8);
        check_val("simul_overrun", 32'(Overrun), 32'd0);
        repeat (8) pop_check("drain");
        check_val("drain_count", 32'(Count), 32'd0);
        check_val("drain_valid", 32'(DataValid), 32'd0);
        check_val("errcount_zero", 32'(ErrCount), 32'd0);

        // error frames: saturating counter and stored error flag
        for (int i = 0; i < 300; i++) begin
            do_frame(8'(i + 16), 1'b1, 0);
            pop_check("err");
            if (i == 99) begin
                check_val("errcount_100", 32'(ErrCount), 32'(err_model));
            end
        end
        check_val("errcount_sat", 32'(ErrCount), 32'(err_model));

        // abandoned frame via timeout, pending config applied afterwards
        start_frame();
        CfgBaud = 2'b01; CfgParity = 2'b10; CfgStop = 1'b0; CfgWr = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!Busy) break;
            busy_n++;
            tick();
            CfgWr = 1'b0;
        end
        CfgWr = 1'b0;
        check_val("timeout_busy_cycles", 32'(busy_n), 32'(FRAME_TIMEOUT));
        check_val("timeout_count", 32'(Count), 32'd0);
        found = 0;
        for (int i = 0; i < 5; i++) begin
            if (CfgAck) begin
                found = 1;
                break;
            end
            tick();
        end
        check_val("timeout_cfg_ack", 32'(found), 32'd1);
        check_val("timeout_cfg", 32'({BaudRate, ParityMode, StopBits}), 32'b01_10_0);
        repeat (3) tick();

        // reset in the middle of a frame with pending config and a ready edge
        start_frame();
        CfgBaud = 2'b11; CfgParity = 2'b01; CfgStop = 1'b1; CfgWr = 1'b1;
        tick();
        CfgWr = 1'b0;
        RxData = 8'h77; Error = 1'b1; RxDataReady = 1'b1;
        RST = 1'b1;
        a0 = ack_total;
        tick();
        tick();
        RxDataReady = 1'b0;
        Error = 1'b0;
        tick();
        RST = 1'b0;
        repeat (5) tick();
        check_val("midrst_busy", 32'(Busy), 32'd0);
        check_val("midrst_count", 32'(Count), 32'd0);
        check_val("midrst_errcount", 32'(ErrCount), 32'd0);
        check_val("midrst_ack", 32'(ack_total - a0), 32'd0);
        check_val("midrst_cfg", 32'({BaudRate, ParityMode, StopBits}), 32'b00_10_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 8: receive FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter FRAME_TIMEOUT, default 65535: CLK cycles after which a frame in progress is abandoned.
REQ-003 SHALL have port CLK  in  1  clock.
REQ-004 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port Rx  in  1  raw serial line, monitored in parallel with the receiver.
REQ-006 SHALL have ports CfgBaud  in  2, CfgParity  in  2 and CfgStop  in  1: requested configuration.
REQ-007 SHALL have port CfgWr  in  1  one-cycle request to load Cfg* as pending.
REQ-008 SHALL have port CfgAck  out  1  one-cycle pulse when pending config is applied.
REQ-009 SHALL have ports BaudRate  out  2, ParityMode  out  2 and StopBits  out  1: applied config driven to the receiver.
REQ-010 SHALL have ports RxData  in  8, RxDataReady  in  1 and Error  in  1, from the receiver; RxDataReady is a level held for multiple cycles.
REQ-011 SHALL have ports DataOut  out  8, DataErr  out  1 and DataValid  out  1: FIFO head (show-ahead).
REQ-012 SHALL have port DataReady  in  1  consumer pop; pop occurs when DataValid && DataReady.
REQ-013 SHALL have port Count  out  5  FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have ports Overrun  out  1 (sticky) and OverrunClr  in  1.
REQ-015 SHALL have port ErrCount  out  8  saturating count of frames with Error=1.
REQ-016 SHALL have port Busy  out  1  high while a frame is in progress.

Function
REQ-017 Rx SHALL pass a 2-flop synchronizer; frame start = synchronized falling edge while IDLE.
REQ-018 FSM SHALL have states IDLE, FRAME and APPLY; IDLE->FRAME on frame start; FRAME->IDLE on RxDataReady rising edge or timeout; IDLE->APPLY when pending valid and no frame start this cycle; APPLY->IDLE unconditionally after 1 cycle.
REQ-019 In APPLY, BaudRate/ParityMode/StopBits SHALL update from pending, pending SHALL clear, and CfgAck SHALL pulse in the same cycle.
REQ-020 Config outputs SHALL never change in FRAME; CfgWr during FRAME SHALL be held pending until IDLE.
REQ-021 CfgWr while already pending SHALL overwrite pending (last write wins, one CfgAck).
REQ-022 Timeout counter SHALL reset on FRAME entry; reaching FRAME_TIMEOUT SHALL return to IDLE with no push.
REQ-023 A push SHALL occur in the cycle after the RxDataReady rising edge is detected, capturing {Error, RxData}; exactly one push per rising edge.
REQ-024 FIFO read latency SHALL be 0 (DataOut valid with DataValid); a pushed byte SHALL first appear on DataValid the cycle after the push.
REQ-025 Push and pop in the same cycle SHALL both take effect; Count unchanged, no overrun even when full.
REQ-026 Push when full without pop SHALL drop the byte and set Overrun; FIFO contents unchanged.
REQ-027 OverrunClr SHALL clear Overrun; a simultaneous new overrun SHALL win (Overrun stays 1).
REQ-028 ErrCount SHALL increment on every detected frame with Error=1, including dropped frames, and saturate at 255.
REQ-029 Pointers SHALL wrap modulo DEPTH; Count SHALL distinguish full (DEPTH) from empty (0).
REQ-030 Busy SHALL equal (state == FRAME).

Reset
REQ-031 RST SHALL set: state IDLE; pending cleared; BaudRate=00, ParityMode=10 (no parity), StopBits=0; CfgAck=0; FIFO empty, Count=0, DataValid=0; DataOut=0, DataErr=0; Overrun=0; ErrCount=0; Busy=0; synchronizer flops=1 (line idle).
REQ-032 RST mid-frame SHALL abandon the frame with no push, no CfgAck, and lose pending config.

Structure
REQ-033 Shared package uart_pkg SHALL hold parity encodings (EVEN=00, ODD=01, NONE=1x), baud codes, reset config constants and FSM state encoding.
REQ-034 FIFO SHALL be a sub-module uart_rx_fifo (DEPTH, width 9, push/pop/full/empty/count).

Verification
REQ-035 Idle, CfgWr {Baud=10, Parity=01, Stop=1} -> CfgAck 2 cycles later; BaudRate=10, ParityMode=01, StopBits=1.
REQ-036 Rx falls, CfgWr mid-frame, RxDataReady rises -> config stays unchanged until frame ends; then CfgAck once with new values.
REQ-037 9 frames 0x01..0x09, no pops, DEPTH=8 -> Count=8, Overrun=1, pops return 0x01..0x08 in order.
REQ-038 Full FIFO, push 0xAA with simultaneous pop -> Count stays 8, Overrun=0, 0xAA last out.
REQ-039 300 frames with Error=1 -> ErrCount=255; DataErr=1 on each stored entry.
REQ-040 Rx falls, no RxDataReady, FRAME_TIMEOUT=100 -> Busy drops after 100 cycles, Count unchanged, pending config then applied.
